// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-wide memory bus masters.
// Holds the store size encodings, I/O window bounds and store controller states.
package riscv_mem_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [31:0] IO_STOP = 32'h0003_0004;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    // Number of bus bytes a store occupies; the reserved size moves no bytes.
    function automatic logic [2:0] size_to_count(input logic [1:0] size);
        logic [2:0] cnt;
        cnt = 3'd0;
        case (size)
            SZ_B:    cnt = 3'd1;
            SZ_H:    cnt = 3'd2;
            SZ_W:    cnt = 3'd4;
            default: cnt = 3'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/mem_store_ctrl.sv
// Write-side master of the byte-wide memory bus: accepts one SB/SH/SW store
// and serialises it little-endian into single-byte write cycles.
module mem_store_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [1:0]        req_size_i,
    input  logic              gnt_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    logic [1:0]        state;
    logic [1:0]        idx;
    logic [2:0]        count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              handshake;
    logic              in_write;
    logic              last_byte;
    logic [7:0]        lane;

    assign in_write    = (state == ST_WRITE) && !rst_in;
    assign req_ready_o = (state == ST_IDLE) && rdy_in && !rst_in;
    assign handshake   = req_valid_i && req_ready_o;
    assign last_byte   = ({1'b0, idx} == (count_q - 3'd1));

    assign mem_wr_o = in_write && gnt_i && rdy_in;
    assign busy_o   = (state != ST_IDLE);
    assign done_o   = (state == ST_FIN) && !rst_in;
    assign err_o    = done_o && err_q;

    // Byte-lane select for the current index, little-endian.
    always_comb begin
        lane = 8'h00;
        case (idx)
            2'd0: lane = data_q[7:0];
            2'd1: lane = data_q[15:8];
            2'd2: lane = data_q[23:16];
            2'd3: lane = data_q[31:24];
            default: lane = 8'h00;
        endcase
    end

    // Outputs are zero outside WRITE so the arbiter can OR all masters together.
    assign mem_a_o    = in_write ? (addr_q + {{(ADDR_W-2){1'b0}}, idx}) : '0;
    assign mem_dout_o = in_write ? lane : 8'h00;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            idx     <= 2'd0;
            count_q <= 3'd0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        addr_q  <= req_addr_i;
                        data_q  <= req_data_i;
                        count_q <= size_to_count(req_size_i);
                        idx     <= 2'd0;
                        if (req_size_i == SZ_RSV) begin
                            err_q <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (gnt_i) begin
                        idx <= idx + 2'd1;
                        if (last_byte) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Directed self-checking bench for mem_store_ctrl: byte serialisation, stalls,
// address wrap, mid-store reset and the reserved size.
module tb_mem_store_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic [1:0]  req_size_i;
    logic        gnt_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks;
    int failures;
    int wrCount;
    int wrBase;

    mem_store_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_size_i  (req_size_i),
        .gnt_i       (gnt_i),
        .mem_a_o     (mem_a_o),
        .mem_dout_o  (mem_dout_o),
        .mem_wr_o    (mem_wr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Counts every byte actually strobed onto the bus.
    initial wrCount = 0;
    always @(posedge clk_in) begin
        if (mem_wr_o === 1'b1) wrCount++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        req_addr_i  = addr;
        req_data_i  = data;
        req_size_i  = size;
        req_valid_i = 1'b1;
        #1;
        checkOutput("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic expectWrite(input string tag, input logic [31:0] addr, input logic [7:0] data);
        #1;
        checkOutput({tag, "_wr"}, {31'b0, mem_wr_o}, 32'd1);
        checkOutput({tag, "_addr"}, mem_a_o, addr);
        checkOutput({tag, "_data"}, {24'b0, mem_dout_o}, {24'b0, data});
        tick();
    endtask

    task automatic expectGap(input string tag, input logic [31:0] addr, input logic [7:0] data);
        #1;
        checkOutput({tag, "_wr"}, {31'b0, mem_wr_o}, 32'd0);
        checkOutput({tag, "_addr"}, mem_a_o, addr);
        checkOutput({tag, "_data"}, {24'b0, mem_dout_o}, {24'b0, data});
        checkOutput({tag, "_done"}, {31'b0, done_o}, 32'd0);
        tick();
    endtask

    task automatic expectFin(input string tag, input logic err);
        #1;
        checkOutput({tag, "_done"}, {31'b0, done_o}, 32'd1);
        checkOutput({tag, "_err"}, {31'b0, err_o}, {31'b0, err});
        checkOutput({tag, "_wr"}, {31'b0, mem_wr_o}, 32'd0);
        checkOutput({tag, "_addr"}, mem_a_o, 32'd0);
        checkOutput({tag, "_ready"}, {31'b0, req_ready_o}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
        tick();
        checkOutput({tag, "_done_drop"}, {31'b0, done_o}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = 32'd0;
        req_data_i  = 32'd0;
        req_size_i  = 2'b00;
        gnt_i       = 1'b0;

        tick();
        tick();
        checkOutput("rst_ready", {31'b0, req_ready_o}, 32'd0);
        checkOutput("rst_wr", {31'b0, mem_wr_o}, 32'd0);
        rst_in = 1'b0;
        #1;
        checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'b0, done_o}, 32'd0);
        checkOutput("rst_err", {31'b0, err_o}, 32'd0);
        checkOutput("rst_addr", mem_a_o, 32'd0);
        checkOutput("rst_dout", {24'b0, mem_dout_o}, 32'd0);
        checkOutput("rst_ready_after", {31'b0, req_ready_o}, 32'd1);

        // SW, continuous grant
        gnt_i = 1'b1;
        applyStimulus(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
        #1;
        checkOutput("sw_busy", {31'b0, busy_o}, 32'd1);
        checkOutput("sw_ready_busy", {31'b0, req_ready_o}, 32'd0);
        expectWrite("sw_b0", 32'h0000_0100, 8'hEF);
        expectWrite("sw_b1", 32'h0000_0101, 8'hBE);
        expectWrite("sw_b2", 32'h0000_0102, 8'hAD);
        expectWrite("sw_b3", 32'h0000_0103, 8'hDE);
        expectFin("sw_fin", 1'b0);

        // SB into the I/O window, then SH across a 128 KiB boundary
        applyStimulus(32'h0003_0000, 32'h0000_0041, 2'b00);
        expectWrite("sb_io", 32'h0003_0000, 8'h41);
        expectFin("sb_fin", 1'b0);
        applyStimulus(32'h0001_FFFF, 32'h0000_1234, 2'b01);
        expectWrite("sh_b0", 32'h0001_FFFF, 8'h34);
        expectWrite("sh_b1", 32'h0002_0000, 8'h12);
        expectFin("sh_fin", 1'b0);

        // SW with grant gap and CPU stall
        wrBase = wrCount;
        applyStimulus(32'h0000_0200, 32'h4433_2211, 2'b10);
        expectWrite("gap_b0", 32'h0000_0200, 8'h11);
        gnt_i = 1'b0;
        expectGap("gnt_gap0", 32'h0000_0201, 8'h22);
        expectGap("gnt_gap1", 32'h0000_0201, 8'h22);
        expectGap("gnt_gap2", 32'h0000_0201, 8'h22);
        gnt_i = 1'b1;
        expectWrite("gap_b1", 32'h0000_0201, 8'h22);
        rdy_in = 1'b0;
        expectGap("rdy_gap0", 32'h0000_0202, 8'h33);
        expectGap("rdy_gap1", 32'h0000_0202, 8'h33);
        rdy_in = 1'b1;
        expectWrite("gap_b2", 32'h0000_0202, 8'h33);
        expectWrite("gap_b3", 32'h0000_0203, 8'h44);
        // Stall in FIN holds the done pulse without repeating it afterwards
        rdy_in = 1'b0;
        #1;
        checkOutput("fin_stall_done", {31'b0, done_o}, 32'd1);
        tick();
        rdy_in = 1'b1;
        expectFin("gap_fin", 1'b0);
        checkOutput("gap_total_writes", wrCount - wrBase, 32'd4);

        // SW wrapping the top of the address space
        applyStimulus(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
        expectWrite("wrap_b0", 32'hFFFF_FFFE, 8'hD4);
        expectWrite("wrap_b1", 32'hFFFF_FFFF, 8'hC3);
        expectWrite("wrap_b2", 32'h0000_0000, 8'hB2);
        expectWrite("wrap_b3", 32'h0000_0001, 8'hA1);
        expectFin("wrap_fin", 1'b0);

        // Reset after the second byte abandons the store
        applyStimulus(32'h0000_0300, 32'h8765_4321, 2'b10);
        expectWrite("rst_b0", 32'h0000_0300, 8'h21);
        expectWrite("rst_b1", 32'h0000_0301, 8'h43);
        rst_in = 1'b1;
        #1;
        checkOutput("midrst_wr", {31'b0, mem_wr_o}, 32'd0);
        checkOutput("midrst_done", {31'b0, done_o}, 32'd0);
        tick();
        rst_in = 1'b0;
        #1;
        checkOutput("midrst_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("midrst_ready", {31'b0, req_ready_o}, 32'd1);
        checkOutput("midrst_wr_after", {31'b0, mem_wr_o}, 32'd0);
        tick();
        checkOutput("midrst_no_done", {31'b0, done_o}, 32'd0);

        // Reserved size, then an SB held valid behind it
        wrBase = wrCount;
        applyStimulus(32'h0000_0400, 32'h0000_0055, 2'b11);
        req_addr_i  = 32'h0000_0500;
        req_data_i  = 32'h0000_00AB;
        req_size_i  = 2'b00;
        req_valid_i = 1'b1;
        #1;
        checkOutput("rsv_done", {31'b0, done_o}, 32'd1);
        checkOutput("rsv_err", {31'b0, err_o}, 32'd1);
        checkOutput("rsv_wr", {31'b0, mem_wr_o}, 32'd0);
        checkOutput("rsv_ready", {31'b0, req_ready_o}, 32'd0);
        tick();
        checkOutput("rsv_done_drop", {31'b0, done_o}, 32'd0);
        checkOutput("rsv_err_drop", {31'b0, err_o}, 32'd0);
        checkOutput("rsv_no_writes", wrCount - wrBase, 32'd0);
        applyStimulus(32'h0000_0500, 32'h0000_00AB, 2'b00);
        expectWrite("rsv_sb", 32'h0000_0500, 8'hAB);
        expectFin("rsv_sb_fin", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_store_ctrl.md
Name: mem_store_ctrl

Overview:
- Write-side bus master for the byte-wide memory bus.
- Takes one store request (SB/SH/SW) from the pipeline through a valid/ready handshake and serialises it into 1–4 single-byte write cycles, little-endian.
- Complements the instruction fetch unit, which reads the same bus. Sits between the MEM stage and the bus arbiter, which grants it the bus.

Parameters:
- ADDR_W, 32, address bus width; the memory map decodes only bits 17:0.
- DATA_W, 32, store data width; must be 32.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  CPU ready; low = freeze all state, no bus activity
- req_valid_i  input  1  store request valid
- req_ready_o  output  1  controller can accept a request
- req_addr_i  input  32  byte address of the store
- req_data_i  input  32  store data; low bytes are used for SB/SH
- req_size_i  input  2  00=byte, 01=half, 10=word, 11=reserved
- gnt_i  input  1  bus granted by the arbiter this cycle
- mem_a_o  output  32  bus address
- mem_dout_o  output  8  bus write data
- mem_wr_o  output  1  bus write strobe (1 = write)
- busy_o  output  1  a request is latched and not yet finished
- done_o  output  1  one-cycle pulse: request finished
- err_o  output  1  one-cycle pulse with done_o when the size was reserved

Behaviour:
- Every clock, reset and stall decision is on clk_in; reset is synchronous and active-high.
- Reset values:
  - state = IDLE, byte index = 0, remaining count = 0.
  - mem_wr_o = 0, mem_a_o = 0, mem_dout_o = 0.
  - busy_o = 0, done_o = 0, err_o = 0.
- States: IDLE, WRITE, FIN.
- IDLE:
  - req_ready_o = 1 when rdy_in = 1 and rst_in = 0; otherwise 0.
  - A handshake is req_valid_i & req_ready_o. On a handshake, latch the address, data and size.
  - Set the count: 1 for byte, 2 for half, 4 for word. Clear the index.
  - Go to WRITE for a legal size, or to FIN with the error flag set for the reserved size.
- WRITE (combinational bus drive):
  - mem_wr_o = gnt_i & rdy_in & ~rst_in.
  - mem_a_o = latched address + index, modulo 2^32; 0xFFFFFFFF + 1 wraps to 0x00000000.
  - mem_dout_o = latched data[8*index+7 : 8*index].
  - On each cycle with mem_wr_o = 1, increment the index.
  - After the last byte (index == count-1 while writing), go to FIN.
  - gnt_i = 0 or rdy_in = 0: no write, index holds, address and data stay stable.
- FIN:
  - done_o = 1 for exactly one cycle; err_o = error flag. Then return to IDLE, clear the error flag.
  - req_ready_o = 0 in FIN.
- Latency: from handshake to done_o is count+1 cycles with continuous grant; SW = 5, SB = 2. Reserved size: done_o and err_o one cycle after the handshake, with zero bus writes.
- busy_o = 1 in WRITE and FIN.
- mem_wr_o = 0, mem_a_o = 0 and mem_dout_o = 0 whenever the state is not WRITE, so the arbiter can OR bus outputs.
- rdy_in low in any state: the state, index, latches and done_o pulse are frozen. done_o stays asserted only if it was already due; it is not counted twice.
- Misaligned addresses are legal; every byte is an independent access. No alignment exception.
- I/O region (address bit 17 = 1): bytes are written as-is. The 0x00-on-UART filtering is done by the peripheral, not here.
- Reset mid-store: the store is abandoned in the reset cycle; mem_wr_o is forced low combinationally and no partial completion is reported.
- Requests arriving while busy are not accepted (req_ready_o = 0); the source holds req_valid_i.

Decomposition:
- Shared package riscv_mem_pkg:
  - size encodings: SZ_B, SZ_H, SZ_W, SZ_RSV
  - IO_BASE = 0x30000, IO_STOP = 0x30004
  - state enum for mem_store_ctrl
- Sub-modules: none. The byte-lane select is a small internal mux, not a separate module.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, gnt_i = 1: writes EF@0x100, BE@0x101, AD@0x102, DE@0x103 on 4 consecutive cycles; done_o 1 cycle later; err_o = 0.
- SB, addr 0x30000, data 0x00000041: one write of 0x41 @0x30000, done_o next cycle. Then SH, addr 0x1FFFF, data 0x1234: 34@0x1FFFF, 12@0x20000.
- SW with gnt_i low for 3 cycles after the first byte, and rdy_in low for 2 cycles during the third byte: mem_wr_o = 0 during both gaps; bytes in order, no duplicates; total writes = 4.
- SW at 0xFFFFFFFE: bytes @0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- rst_in asserted after the 2nd byte of an SW: mem_wr_o = 0 that cycle; IDLE, req_ready_o = 1 after reset; no done_o.
- Reserved size (11) followed immediately by an SB request held valid: done_o = err_o = 1 one cycle after the first handshake, no bus write; SB accepted the next cycle in IDLE and completes normally.
